// File: rtl/ppc_ebi_pkg.sv
// Shared types and constants for the PowerPC EBI slave.
package ppc_ebi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned TO_CNT_W = 8;

    // Read data returned to the host when the internal target never acknowledges
    localparam logic [255:0] RD_ABORT_WORD = '1;

    // Width of a chip-select index; at least one bit even for a single channel
    function automatic int unsigned cs_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppc_ebi_slave_if.sv
// Internal request/acknowledge bus between the EBI slave and the register/RAM target.
interface ppc_ebi_slave_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CS = 2
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned CS_W = ppc_ebi_pkg::cs_idx_w(NUM_CS);

    logic              req_o;
    logic              req_we;
    logic [CS_W-1:0]   req_cs;
    logic [ADDR_W-3:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              ack_i;
    logic [DATA_W-1:0] rdata_i;

    modport master (
        output req_o, req_we, req_cs, req_addr, req_be, req_wdata,
        input  ack_i, rdata_i
    );

    modport slave (
        input  req_o, req_we, req_cs, req_addr, req_be, req_wdata,
        output ack_i, rdata_i
    );
endinterface

// File: rtl/ppc_sync_bus.sv
// Per-bit multi-flop synchroniser with a configurable (inactive) reset value.
module ppc_sync_bus #(
    parameter int unsigned    W       = 1,
    parameter int unsigned    STAGES  = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];
endmodule

// File: rtl/ppc_ebi_slave.sv
// PowerPC EBI slave: synchronises NUM_CS chip selects and strobes and runs one internal
// request per EBI access with timeout. Define PPC_TA_EN to add the ta_n transfer acknowledge.
module ppc_ebi_slave
    import ppc_ebi_pkg::*;
#(
    parameter int unsigned  ADDR_W      = 24,
    parameter int unsigned  DATA_W      = 32,
    parameter int unsigned  NUM_CS      = 2,
    parameter int unsigned  SYNC_STAGES = 2,
    parameter int unsigned  TIMEOUT     = 255,
    localparam int unsigned BE_W        = DATA_W / 8,
    localparam int unsigned CS_W        = cs_idx_w(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CS-1:0] cs_n,
    input  logic              oe_n,
    input  logic [BE_W-1:0]   we_n,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] ebi_addr,
    input  logic [DATA_W-1:0] ebi_din,
    output logic [DATA_W-1:0] ebi_dout,
    output logic              ebi_dout_oe,
`ifdef PPC_TA_EN
    output logic              ta_n,
`endif
    output logic              err_o,
    ppc_ebi_slave_if.master   bus
);
    localparam int unsigned       CTL_W    = NUM_CS + 1 + BE_W + 1;
    localparam logic [CTL_W-1:0]  CTL_IDLE = {{NUM_CS{1'b1}}, 1'b1, {BE_W{1'b1}}, 1'b0};

    logic [CTL_W-1:0]  ctl_s;
    logic [NUM_CS-1:0] cs_n_s;
    logic              oe_n_s;
    logic [BE_W-1:0]   we_n_s;
    logic              rd_wr_s;

    ppc_sync_bus #(
        .W       (CTL_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CTL_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({cs_n, oe_n, we_n, rd_wr}),
        .q   (ctl_s)
    );

    assign {cs_n_s, oe_n_s, we_n_s, rd_wr_s} = ctl_s;

    // Chip-select decode: lowest active index, plus a flag when several are active
    logic            cs_any;
    logic            cs_multi;
    logic [CS_W-1:0] cs_idx;

    always_comb begin
        cs_any   = 1'b0;
        cs_multi = 1'b0;
        cs_idx   = '0;
        for (int i = int'(NUM_CS) - 1; i >= 0; i--) begin
            if (!cs_n_s[i]) begin
                cs_multi = cs_multi | cs_any;
                cs_any   = 1'b1;
                cs_idx   = CS_W'(i);
            end
        end
    end

    logic qual;
    logic qual_q;
    logic start;

    assign qual  = cs_any & ((~rd_wr_s & (we_n_s != '1)) |
                             ( rd_wr_s & (we_n_s == '1) & ~oe_n_s));
    assign start = qual & ~qual_q;

    state_e              state, state_d;
    logic [TO_CNT_W-1:0] cnt, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dout_d;
    logic                oe_d;
    logic                err_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        req_d   = req_q;
        we_d    = we_q;
        cs_d    = cs_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        dout_d  = ebi_dout;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cs_multi) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        we_d    = ~rd_wr_s;
                        cs_d    = cs_idx;
                        addr_d  = ebi_addr[ADDR_W-1:2];
                        be_d    = rd_wr_s ? '1 : ~we_n_s;
                        wdata_d = ebi_din;
                    end
                end
            end
            REQ: begin
                // Acknowledge wins over a timeout landing on the same cycle
                if (bus.ack_i) begin
                    state_d = HOLD;
                    req_d   = 1'b0;
                    if (!we_q) dout_d = bus.rdata_i;
                end else if (cnt == TO_CNT_W'(TIMEOUT)) begin
                    state_d = HOLD;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) dout_d = DATA_W'(RD_ABORT_WORD);
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (&cs_n_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        oe_d = (state_d == HOLD) & ~we_d & ~oe_n_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            qual_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            cs_q        <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            ebi_dout    <= '0;
            ebi_dout_oe <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            qual_q      <= qual;
            req_q       <= req_d;
            we_q        <= we_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            ebi_dout    <= dout_d;
            ebi_dout_oe <= oe_d;
            err_o       <= err_d;
        end
    end

`ifdef PPC_TA_EN
    // One-cycle acknowledge on every entry to HOLD, whether acked or aborted
    logic hold_entry;
    assign hold_entry = (state == REQ) && (state_d == HOLD);

    always_ff @(posedge clk) begin
        if (rst) ta_n <= 1'b1;
        else     ta_n <= ~hold_entry;
    end
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ebi_addr[1:0];

    assign bus.req_o     = req_q;
    assign bus.req_we    = we_q;
    assign bus.req_cs    = cs_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_be    = be_q;
    assign bus.req_wdata = wdata_q;
endmodule

// File: tb/tb_ppc_ebi_slave.sv
// Self-checking bench for ppc_ebi_slave: directed table, corner sequences, random accesses.
module tb_ppc_ebi_slave;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_CS  = 2;
    localparam int unsigned SYNC    = 2;
    localparam int          TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs_n;
    logic        oe_n;
    logic [3:0]  we_n;
    logic        rd_wr;
    logic [23:0] ebi_addr;
    logic [31:0] ebi_din;
    logic [31:0] ebi_dout;
    logic        ebi_dout_oe;
    logic        err_o;
`ifdef PPC_TA_EN
    logic        ta_n;
`endif

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   req_rises  = 0;
    int   err_pulses = 0;
    logic req_prev   = 1'b0;
    logic [31:0] mdl_dout;

    ppc_ebi_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();

    ppc_ebi_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS),
        .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n), .rd_wr(rd_wr),
        .ebi_addr(ebi_addr), .ebi_din(ebi_din), .ebi_dout(ebi_dout),
        .ebi_dout_oe(ebi_dout_oe),
`ifdef PPC_TA_EN
        .ta_n(ta_n),
`endif
        .err_o(err_o), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.req_o && !req_prev) req_rises++;
        req_prev = bus.req_o;
        if (err_o) err_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  cs_n;
        logic        rd;
        logic [3:0]  we_n;
        logic [23:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
        int          ack_dly;
        int          hold;
        logic        exp_req;
        logic        exp_err;
        logic        exp_cs;
        logic [3:0]  exp_be;
        logic [21:0] exp_addr;
        logic [31:0] exp_dout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [1:0] cs, logic rd, logic [3:0] we, logic [23:0] a,
                                logic [31:0] d, logic [31:0] rdat, int ack, int hold,
                                logic xreq, logic xerr, logic xcs, logic [3:0] xbe,
                                logic [21:0] xa, logic [31:0] xdout);
        vec_t v;
        v.cs_n = cs; v.rd = rd; v.we_n = we; v.addr = a; v.din = d; v.rdata = rdat;
        v.ack_dly = ack; v.hold = hold; v.exp_req = xreq; v.exp_err = xerr;
        v.exp_cs = xcs; v.exp_be = xbe; v.exp_addr = xa; v.exp_dout = xdout;
        return v;
    endfunction

    // Reference model: expectations from the access rules, tracking the last read data
    function automatic vec_t model(input vec_t s);
        vec_t e;
        int   lows;
        logic timed_out;
        e = s;
        lows = 0;
        for (int i = 0; i < 2; i++) if (s.cs_n[i] == 1'b0) lows++;
        timed_out  = (s.ack_dly > TIMEOUT);
        e.exp_req  = (lows == 1);
        e.exp_err  = (lows > 1) || (lows == 1 && timed_out);
        e.exp_cs   = (s.cs_n[0] == 1'b0) ? 1'b0 : 1'b1;
        e.exp_be   = s.rd ? 4'hF : ~s.we_n;
        e.exp_addr = 22'(s.addr / 4);
        if (lows == 1 && s.rd) mdl_dout = timed_out ? 32'hFFFF_FFFF : s.rdata;
        e.exp_dout = mdl_dout;
        return e;
    endfunction

    task automatic wait_req(output int n);
        n = 13;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus.req_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic release_bus();
        cs_n = 2'b11; rd_wr = 1'b0; we_n = 4'hF; oe_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, c, r0, e0, exp_len;
        r0 = req_rises;
        e0 = err_pulses;
        ebi_addr = v.addr; ebi_din = v.din; rd_wr = v.rd;
        we_n = v.rd ? 4'hF : v.we_n;
        oe_n = ~v.rd;
        cs_n = v.cs_n;
        wait_req(n);
        if (v.exp_req) begin
            check({tag, ".req_latency"}, 64'(n), 64'(SYNC + 1));
            if (n <= 12) begin
                check({tag, ".req_we"}, 64'(bus.req_we), 64'(!v.rd));
                check({tag, ".req_cs"}, 64'(bus.req_cs), 64'(v.exp_cs));
                check({tag, ".req_addr"}, 64'(bus.req_addr), 64'(v.exp_addr));
                check({tag, ".req_be"}, 64'(bus.req_be), 64'(v.exp_be));
                if (!v.rd) check({tag, ".req_wdata"}, 64'(bus.req_wdata), 64'(v.din));
                exp_len = (v.ack_dly > TIMEOUT) ? TIMEOUT + 1 : v.ack_dly + 1;
                c = 0;
                while (bus.req_o && c <= TIMEOUT + 4) begin
                    if (c == v.ack_dly) begin
                        bus.ack_i = 1'b1;
                        bus.rdata_i = v.rdata;
                    end
                    @(posedge clk); #1;
                    bus.ack_i = 1'b0;
                    c++;
                end
                check({tag, ".req_cycles"}, 64'(c), 64'(exp_len));
                check({tag, ".err_at_done"}, 64'(err_o), 64'(v.exp_err));
                check({tag, ".ebi_dout"}, 64'(ebi_dout), 64'(v.exp_dout));
                check({tag, ".dout_oe"}, 64'(ebi_dout_oe), 64'(v.rd));
`ifdef PPC_TA_EN
                check({tag, ".ta_low"}, 64'(ta_n), 64'(0));
`endif
                @(posedge clk); #1;
                check({tag, ".err_cleared"}, 64'(err_o), 64'(0));
`ifdef PPC_TA_EN
                check({tag, ".ta_high"}, 64'(ta_n), 64'(1));
`endif
            end
        end else begin
            check({tag, ".req_absent"}, 64'(n), 64'(13));
        end
        repeat (v.hold) @(posedge clk);
        #1;
        if (v.exp_req && v.rd) begin
            oe_n = 1'b1;
            n = 9;
            for (int i = 1; i <= 8; i++) begin
                @(posedge clk); #1;
                if (!ebi_dout_oe) begin
                    n = i;
                    break;
                end
            end
            check({tag, ".oe_release_latency"}, 64'(n), 64'(SYNC + 1));
        end
        release_bus();
        repeat (SYNC + 3) @(posedge clk);
        #1;
        check({tag, ".req_idle"}, 64'(bus.req_o), 64'(0));
        check({tag, ".req_count"}, 64'(req_rises - r0), 64'(v.exp_req));
        check({tag, ".err_count"}, 64'(err_pulses - e0), 64'(v.exp_err));
    endtask

    vec_t tbl [6];

    initial begin
        int n, r0, e0;
        vec_t s;

        tbl[0] = mk(2'b10, 1'b0, 4'b0000, 24'h000104, 32'hDEADBEEF, 32'h0, 2, 0,
                    1'b1, 1'b0, 1'b0, 4'hF, 22'h000041, 32'h0);
        tbl[1] = mk(2'b01, 1'b1, 4'hF, 24'h000010, 32'h0, 32'h12345678, 1, 2,
                    1'b1, 1'b0, 1'b1, 4'hF, 22'h000004, 32'h12345678);
        tbl[2] = mk(2'b10, 1'b0, 4'b1110, 24'h000200, 32'h000000AA, 32'h0, 0, 20,
                    1'b1, 1'b0, 1'b0, 4'b0001, 22'h000080, 32'h12345678);
        tbl[3] = mk(2'b10, 1'b1, 4'hF, 24'h0000FC, 32'h0, 32'h0, 1000, 0,
                    1'b1, 1'b1, 1'b0, 4'hF, 22'h00003F, 32'hFFFFFFFF);
        tbl[4] = mk(2'b00, 1'b0, 4'b0000, 24'h000008, 32'h11111111, 32'h0, 0, 0,
                    1'b0, 1'b1, 1'b0, 4'hF, 22'h000002, 32'hFFFFFFFF);
        tbl[5] = mk(2'b01, 1'b1, 4'hF, 24'hFFFFFC, 32'h0, 32'hA5A5A5A5, TIMEOUT, 0,
                    1'b1, 1'b0, 1'b1, 4'hF, 22'h3FFFFF, 32'hA5A5A5A5);

        rst = 1'b1;
        release_bus();
        ebi_addr = '0; ebi_din = '0;
        bus.ack_i = 1'b0; bus.rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.req_o", 64'(bus.req_o), 64'(0));
        check("reset.ebi_dout", 64'(ebi_dout), 64'(0));
        check("reset.dout_oe", 64'(ebi_dout_oe), 64'(0));
        check("reset.err_o", 64'(err_o), 64'(0));
`ifdef PPC_TA_EN
        check("reset.ta_n", 64'(ta_n), 64'(1));
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Chip select dropped while the request is still pending
        r0 = req_rises;
        cs_n = 2'b10; rd_wr = 1'b0; we_n = 4'h0; oe_n = 1'b1;
        ebi_addr = 24'h000300; ebi_din = 32'h0BADF00D;
        wait_req(n);
        check("csrel.req_latency", 64'(n), 64'(SYNC + 1));
        release_bus();
        repeat (4) @(posedge clk);
        #1;
        check("csrel.req_held", 64'(bus.req_o), 64'(1));
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        check("csrel.req_dropped", 64'(bus.req_o), 64'(0));
        check("csrel.req_count", 64'(req_rises - r0), 64'(1));
        run_vec(mk(2'b01, 1'b1, 4'hF, 24'h000020, 32'h0, 32'hCAFEF00D, 0, 0,
                   1'b1, 1'b0, 1'b1, 4'hF, 22'h000008, 32'hCAFEF00D), "csrel_next");

        // Reset while a request is outstanding
        r0 = req_rises;
        cs_n = 2'b01; rd_wr = 1'b0; we_n = 4'h3; oe_n = 1'b1;
        ebi_addr = 24'h000444; ebi_din = 32'h01020304;
        wait_req(n);
        check("rstmid.req_latency", 64'(n), 64'(SYNC + 1));
        e0 = err_pulses;
        rst = 1'b1;
        release_bus();
        @(posedge clk); #1;
        check("rstmid.req_o", 64'(bus.req_o), 64'(0));
        check("rstmid.err_o", 64'(err_o), 64'(0));
        check("rstmid.ebi_dout", 64'(ebi_dout), 64'(0));
        rst = 1'b0;
        bus.ack_i = 1'b1; bus.rdata_i = 32'h55AA55AA;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstmid.stray_ack_dout", 64'(ebi_dout), 64'(0));
        check("rstmid.req_count", 64'(req_rises - r0), 64'(1));
        check("rstmid.err_count", 64'(err_pulses - e0), 64'(0));
        run_vec(mk(2'b10, 1'b1, 4'hF, 24'h000800, 32'h0, 32'h600DCAFE, 3, 0,
                   1'b1, 1'b0, 1'b0, 4'hF, 22'h000200, 32'h600DCAFE), "rstmid_next");

        // Strobes toggled without releasing chip select must not start a new access
        r0 = req_rises;
        cs_n = 2'b10; rd_wr = 1'b0; we_n = 4'h0; oe_n = 1'b1;
        ebi_addr = 24'h000010; ebi_din = 32'h13572468;
        wait_req(n);
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        we_n = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        we_n = 4'h0; ebi_addr = 24'h000020;
        repeat (8) @(posedge clk);
        #1;
        check("b2b.req_count", 64'(req_rises - r0), 64'(1));
        release_bus();
        repeat (SYNC + 3) @(posedge clk);
        #1;

        // Randomised accesses against the reference model, from a clean reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_dout = 32'h0;
        @(posedge clk); #1;
        for (int k = 0; k < 24; k++) begin
            s.cs_n    = ($urandom_range(0, 9) == 0) ? 2'b00 :
                        ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
            s.rd      = 1'($urandom_range(0, 1));
            s.we_n    = 4'($urandom_range(0, 14));
            s.addr    = 24'($urandom);
            s.din     = $urandom;
            s.rdata   = $urandom;
            s.ack_dly = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 6));
            s.hold    = int'($urandom_range(0, 3));
            s = model(s);
            run_vec(s, $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
